// File: rtl/memory_access_unit_if.sv
// Request and memory-bus signal bundle for the load/store unit.
// slave = the unit itself, master = control unit plus memory side.
interface memory_access_unit_if;
  logic        iStart;
  logic        iWrite;
  logic [1:0]  iSize;
  logic        iUnsigned;
  logic [31:0] iAddress;
  logic [31:0] iStoreData;
  logic [31:0] iMemData;
  logic [31:0] oMemAddress;
  logic [3:0]  oMemByteEnable;
  logic [31:0] oMemWriteData;
  logic        oMemRead;
  logic        oMemWrite;
  logic        oBusy;
  logic        oDone;
  logic        oFault;
  logic [31:0] oLoadData;

  modport slave (
    input  iStart, iWrite, iSize, iUnsigned,
    input  iAddress, iStoreData, iMemData,
    output oMemAddress, oMemByteEnable,
    output oMemWriteData, oMemRead, oMemWrite,
    output oBusy, oDone, oFault, oLoadData
  );

  modport master (
    output iStart, iWrite, iSize, iUnsigned,
    output iAddress, iStoreData, iMemData,
    input  oMemAddress, oMemByteEnable,
    input  oMemWriteData, oMemRead, oMemWrite,
    input  oBusy, oDone, oFault, oLoadData
  );
endinterface

// File: rtl/memory_access_unit.sv
// Multicycle MIPS load/store bus initiator: lane steering,
// fixed-latency read capture, alignment faults.
module memory_access_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic iCLK,
  input logic iRST,
  memory_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [1:0]  r_cnt;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_ld;

  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_sh;
  logic [31:0] w_ext;
  logic        w_accept;
  logic        w_capture;

  assign w_accept  = (r_state == S_IDLE) & bus.iStart;
  assign w_capture = (r_state == S_WAIT) & (r_cnt == 2'd0);

  always_comb begin
    w_misalign = 1'b0;
    unique case (bus.iSize)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = bus.iAddress[0];
      2'b10:   w_misalign = |bus.iAddress[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_be = 4'b0000;
    w_wd = bus.iStoreData;
    unique case (bus.iSize)
      2'b00: begin
        w_be = 4'b0001 << bus.iAddress[1:0];
        w_wd = {4{bus.iStoreData[7:0]}};
      end
      2'b01: begin
        w_be = bus.iAddress[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{bus.iStoreData[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Shift the addressed lane down to bit 0 before extending.
  assign w_sh = bus.iMemData >> {r_off, 3'b000};

  always_comb begin
    w_ext = bus.iMemData;
    unique case (r_size)
      2'b00: w_ext = {{24{w_sh[7] & ~r_unsigned}}, w_sh[7:0]};
      2'b01: w_ext = {{16{w_sh[15] & ~r_unsigned}}, w_sh[15:0]};
      default: w_ext = bus.iMemData;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.iStart)
          w_next = w_misalign ? S_FAULT : S_ISSUE;
      S_ISSUE: w_next = r_write ? S_DONE : S_WAIT;
      S_WAIT:
        if (r_cnt == 2'd0)
          w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
    end else if (w_accept & ~w_misalign) begin
      r_write    <= bus.iWrite;
      r_size     <= bus.iSize;
      r_unsigned <= bus.iUnsigned;
      r_off      <= bus.iAddress[1:0];
      r_addr     <= bus.iAddress[31:2];
      r_be       <= w_be;
      r_wdata    <= w_wd;
    end
  end

  // Strobes and pulses come from the next state so they leave flops.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_rd    <= (w_next == S_ISSUE) & ~bus.iWrite;
      r_wr    <= (w_next == S_ISSUE) & bus.iWrite;
      r_done  <= (w_next == S_DONE);
      r_fault <= (w_next == S_FAULT);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cnt <= 2'd0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= LAT_M1;
    end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)           r_ld <= '0;
    else if (w_capture) r_ld <= w_ext;
  end

  assign bus.oMemAddress    = {r_addr, 2'b00};
  assign bus.oMemByteEnable = r_be;
  assign bus.oMemWriteData  = r_wdata;
  assign bus.oMemRead       = r_rd;
  assign bus.oMemWrite      = r_wr;
  assign bus.oBusy          = (r_state != S_IDLE);
  assign bus.oDone          = r_done;
  assign bus.oFault         = r_fault;
  assign bus.oLoadData      = r_ld;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit at READ_LATENCY=3
// with a delayed-data memory model.
module tb_memory_access_unit;

  localparam int RL = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wr;
    logic [31:0] ld;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t        sbq[$];
  logic [31:0] exp_ld = '0;
  logic [31:0] mem_val = '0;
  logic [RL-1:0] rd_pipe = '0;

  always #5 clk = ~clk;

  memory_access_unit_if bus();

  memory_access_unit #(.READ_LATENCY(RL)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_pipe <= {rd_pipe[RL-2:0], bus.oMemRead};

  assign bus.iMemData = rd_pipe[RL-1] ? mem_val : 32'h5A5A5A5A;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Monitor: every bus strobe, done or fault pulse pops one entry.
  always @(negedge clk) begin
    if (!rst && (bus.oMemRead || bus.oMemWrite ||
                 bus.oDone || bus.oFault)) begin
      int   k;
      bit   ok;
      exp_t e;
      k = (bus.oMemRead || bus.oMemWrite) ? 1 :
          bus.oDone ? 2 : 3;
      total++;
      if (bus.oMemRead && bus.oMemWrite) begin
        bad++;
        $display("FAIL strobes: both high at cycle %0d", cyc);
      end else if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected: event %0d at cycle %0d", k, cyc);
      end else begin
        e = sbq.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc);
        if (k == 1) begin
          ok = ok && bus.oMemAddress === e.addr &&
               bus.oMemByteEnable === e.be &&
               bus.oMemWrite === e.wr &&
               bus.oMemRead === ~e.wr &&
               (!e.wr || bus.oMemWriteData === e.wd);
        end else begin
          ok = ok && bus.oLoadData === e.ld &&
               !(bus.oDone && bus.oFault);
        end
        if (!ok) begin
          bad++;
          $display("FAIL event: got kind=%0d cyc=%0d a=%h be=%b wd=%h r=%b w=%b ld=%h want kind=%0d cyc=%0d a=%h be=%b wd=%h w=%b ld=%h",
                   k, cyc, bus.oMemAddress, bus.oMemByteEnable,
                   bus.oMemWriteData, bus.oMemRead, bus.oMemWrite,
                   bus.oLoadData, e.kind, e.cyc, e.addr, e.be,
                   e.wd, e.wr, e.ld);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++)
      @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d events pending, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] sd);
    bus.iStart     = 1'b1;
    bus.iWrite     = w;
    bus.iSize      = sz;
    bus.iUnsigned  = u;
    bus.iAddress   = a;
    bus.iStoreData = sd;
  endtask

  task automatic expect_ok(input int c0, input logic w,
                           input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] ld);
    exp_t e;
    e = '{1, c0 + 1, {a[31:2], 2'b00}, be, wd, w, 32'h0};
    sbq.push_back(e);
    if (!w) exp_ld = ld;
    e = '{2, c0 + (w ? 2 : RL + 2), 32'h0, 4'h0, 32'h0, 1'b0, exp_ld};
    sbq.push_back(e);
  endtask

  task automatic op(input logic w, input logic [1:0] sz,
                    input logic u, input logic [31:0] a,
                    input logic [31:0] sd, input logic [31:0] mv,
                    input bit flt, input logic [3:0] be,
                    input logic [31:0] wd, input logic [31:0] ld);
    int   c0;
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    mem_val = mv;
    drive(w, sz, u, a, sd);
    if (flt) begin
      e = '{3, c0 + 1, 32'h0, 4'h0, 32'h0, 1'b0, exp_ld};
      sbq.push_back(e);
    end else begin
      expect_ok(c0, w, a, be, wd, ld);
    end
    @(negedge clk);
    bus.iStart = 1'b0;
    drain();
  endtask

  initial begin
    int c0;
    bus.iStart     = 1'b0;
    bus.iWrite     = 1'b0;
    bus.iSize      = 2'b00;
    bus.iUnsigned  = 1'b0;
    bus.iAddress   = '0;
    bus.iStoreData = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", bus.oMemAddress, 32'h0);
    chk("rst_ld", bus.oLoadData, 32'h0);
    chk("rst_ctl", {28'h0, bus.oBusy, bus.oMemRead,
                    bus.oDone, bus.oFault}, 32'h0);
    rst = 1'b0;

    // sb / lh / lhu
    op(1, 2'b00, 0, 32'h13, 32'hAB, 32'h0, 0,
       4'b1000, 32'hABABABAB, 32'h0);
    op(0, 2'b01, 0, 32'h2, 32'h0, 32'h80011234, 0,
       4'b1100, 32'h0, 32'hFFFF8001);
    op(0, 2'b01, 1, 32'h2, 32'h0, 32'h80011234, 0,
       4'b1100, 32'h0, 32'h00008001);
    // faults: lw 0x5, lh 0x3, reserved size
    op(0, 2'b10, 0, 32'h5, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    op(0, 2'b01, 0, 32'h3, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    op(1, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    chk("fault_ld", bus.oLoadData, 32'h00008001);
    // lw latency, lb, lbu, sh, sw
    op(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
       4'b1111, 32'h0, 32'hDEADBEEF);
    op(0, 2'b00, 0, 32'h101, 32'h0, 32'h00008000, 0,
       4'b0010, 32'h0, 32'hFFFFFF80);
    op(0, 2'b00, 1, 32'h103, 32'h0, 32'h7F000000, 0,
       4'b1000, 32'h0, 32'h0000007F);
    op(1, 2'b01, 0, 32'h6, 32'h1234, 32'h0, 0,
       4'b1100, 32'h12341234, 32'h0);
    op(1, 2'b10, 0, 32'h8, 32'hCAFEF00D, 32'h0, 0,
       4'b1111, 32'hCAFEF00D, 32'h0);

    // iStart held high: second accept one IDLE cycle after DONE
    @(negedge clk);
    c0 = cyc;
    mem_val = 32'h11223344;
    drive(0, 2'b10, 0, 32'h200, 32'h0);
    expect_ok(c0, 0, 32'h200, 4'b1111, 32'h0, 32'h11223344);
    expect_ok(c0 + 6, 0, 32'h200, 4'b1111, 32'h0, 32'h11223344);
    repeat (6) @(negedge clk);
    chk("idle_gap_busy", {31'h0, bus.oBusy}, 32'h0);
    @(negedge clk);
    bus.iStart = 1'b0;
    drain();

    // reset during WAIT
    @(negedge clk);
    c0 = cyc;
    mem_val = 32'h99999999;
    drive(0, 2'b10, 0, 32'h300, 32'h0);
    sbq.push_back('{1, c0 + 1, 32'h300, 4'b1111, 32'h0, 1'b0, 32'h0});
    @(negedge clk);
    bus.iStart = 1'b0;
    @(negedge clk);
    chk("wait_busy", {31'h0, bus.oBusy}, 32'h1);
    rst = 1'b1;
    #1;
    exp_ld = '0;
    chk("mid_addr", bus.oMemAddress, 32'h0);
    chk("mid_be", {28'h0, bus.oMemByteEnable}, 32'h0);
    chk("mid_ld", bus.oLoadData, 32'h0);
    chk("mid_ctl", {27'h0, bus.oBusy, bus.oMemRead, bus.oMemWrite,
                    bus.oDone, bus.oFault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("after_rst_q", sbq.size(), 32'h0);
    op(0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D, 0,
       4'b1111, 32'h0, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    chk("final_q", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
